cpu_mem_responder: RTL and testbench

- Memory-side responder for the cpu fetch/load/store interface. It serves instruction fetches and data accesses over a 4K x 16 word space; the 12-bit address is the instruction address field.
- Adds a valid/ready request handshake, a programmable wait-state latency, and a held response.
- Provides a preload port so benches and boot logic can fill program memory before or between cpu transactions.

---
 rtl/cpu_mem_responder_pkg.sv | 35 +++
 rtl/cpu_mem_responder_if.sv | 30 +++
 rtl/cpu_mem_array.sv | 46 ++++
 rtl/cpu_mem_responder.sv | 146 ++++++++++++++
 tb/tb_cpu_mem_responder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths, opcodes, instruction word and responder states.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_JUMP = 4'b0100;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] operand;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic instr_t make_instr(input logic [3:0] op, input logic [11:0] arg);
        instr_t w_i;
        w_i.opcode  = op;
        w_i.operand = arg;
        return w_i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_responder_if
// Brief    : CPU request/response handshake bundle (cpu = master).
// Revision : 1.0
// ============================================================================
interface cpu_mem_responder_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_ready;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/cpu_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_array
// Brief    : Single-port synchronous RAM with preload/cpu write mux.
// Revision : 1.0
// ============================================================================
module cpu_mem_array #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              i_ld_en,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_cpu_we,
    input  logic              i_cpu_re,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];
    logic [DATA_W-1:0] r_rdata;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // The responder never raises a preload and a cpu commit in the same cycle.
    assign w_we    = i_ld_en | i_cpu_we;
    assign w_addr  = i_ld_en ? i_ld_addr : i_cpu_addr;
    assign w_wdata = i_ld_en ? i_ld_data : i_cpu_wdata;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_addr] <= w_wdata;
        end
        if (i_cpu_re) begin
            r_rdata <= r_mem[w_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_responder
// Brief    : Wait-state memory responder for cpu fetch/load/store, with preload.
// Revision : 1.0
// ============================================================================
module cpu_mem_responder #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    cpu_mem_responder_if.slave bus,
    input  logic               ld_en,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               busy,
    output logic               ld_err
);
    import cpu_pkg::*;

    localparam bit         c_zero_lat = (LATENCY == 0);
    localparam logic [3:0] c_cnt_init = c_zero_lat ? 4'd0 : 4'(LATENCY - 1);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_live;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_sel_mem;
    logic [DATA_W-1:0] r_rsp_wdata;
    logic              r_ld_err;

    logic              w_idle, w_req_ready, w_rsp_valid, w_busy;
    logic              w_accept, w_commit;
    logic              w_acc_we;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = bus.req_valid & w_req_ready;

    // With zero latency the commit happens on the accept edge, before the latches load.
    assign w_acc_we    = w_idle ? bus.req_we    : r_we;
    assign w_acc_addr  = w_idle ? bus.req_addr  : r_addr;
    assign w_acc_wdata = w_idle ? bus.req_wdata : r_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (c_zero_lat) begin
                        w_state_nxt = ST_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                    w_commit    = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = w_idle & r_live & ~ld_en;
        w_rsp_valid = (r_state == ST_RESP);
        w_busy      = ~w_idle;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live        <= 1'b0;
            r_cnt         <= 4'd0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rsp_sel_mem <= 1'b0;
            r_rsp_wdata   <= '0;
            r_ld_err      <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_cnt   <= c_cnt_init;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rsp_sel_mem <= ~w_acc_we;
                r_rsp_wdata   <= w_acc_wdata;
            end
            if (ld_en & w_busy) begin
                r_ld_err <= 1'b1;
            end
        end
    end

    cpu_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk         (clk),
        .i_ld_en     (ld_en & w_idle),
        .i_ld_addr   (ld_addr),
        .i_ld_data   (ld_data),
        .i_cpu_we    (w_commit & w_acc_we),
        .i_cpu_re    (w_commit & ~w_acc_we),
        .i_cpu_addr  (w_acc_addr),
        .i_cpu_wdata (w_acc_wdata),
        .o_rdata     (w_mem_rdata)
    );

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rsp_sel_mem ? w_mem_rdata : r_rsp_wdata;
    assign busy          = w_busy;
    assign ld_err        = r_ld_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem_responder
// Brief    : Directed bench for a LATENCY=2 responder and a LATENCY=0 responder.
// Revision : 1.0
// ============================================================================
module tb_cpu_mem_responder;
    import cpu_pkg::*;

    logic        clk;
    logic        reset_a, reset_b;
    logic        ld_en_a, ld_en_b;
    logic [11:0] ld_addr_a, ld_addr_b;
    logic [15:0] ld_data_a, ld_data_b;
    logic        busy_a, busy_b, ld_err_a, ld_err_b;
    int          checks   = 0;
    int          failures = 0;

    cpu_mem_responder_if bus_a ();
    cpu_mem_responder_if bus_b ();

    cpu_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(2)) u_dut_a (
        .clk(clk), .reset(reset_a), .bus(bus_a), .ld_en(ld_en_a), .ld_addr(ld_addr_a),
        .ld_data(ld_data_a), .busy(busy_a), .ld_err(ld_err_a)
    );

    cpu_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(0)) u_dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b), .ld_en(ld_en_b), .ld_addr(ld_addr_b),
        .ld_data(ld_data_b), .busy(busy_b), .ld_err(ld_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload_a(input logic [11:0] a, input logic [15:0] d);
        ld_en_a = 1'b1; ld_addr_a = a; ld_data_a = d;
        @(negedge clk);
        ld_en_a = 1'b0;
    endtask

    task automatic preload_b(input logic [11:0] a, input logic [15:0] d);
        ld_en_b = 1'b1; ld_addr_b = a; ld_data_b = d;
        @(negedge clk);
        ld_en_b = 1'b0;
    endtask

    // One request on responder A, called on a negedge while it is idle.
    task automatic transact(input bit we, input logic [11:0] addr, input logic [15:0] wdata,
                            input logic [15:0] exp, input int hold, input string tag);
        int n;
        bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_addr = addr;
        bus_a.req_wdata = wdata; bus_a.rsp_ready = (hold == 0);
        #1;
        chk($sformatf("%s.req_ready", tag), bus_a.req_ready, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) bus_a.req_valid = 1'b0;
        end while (!bus_a.rsp_valid && n < 20);
        chk($sformatf("%s.latency", tag), n, 3);
        chk($sformatf("%s.rdata", tag), bus_a.rsp_rdata, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk($sformatf("%s.hold%0d", tag, i),
                {bus_a.rsp_valid, bus_a.req_ready, busy_a, bus_a.rsp_rdata}, {3'b101, exp});
        end
        bus_a.rsp_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("%s.done", tag), {bus_a.rsp_valid, busy_a, bus_a.req_ready}, 3'b001);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        ld_en_a = 1'b0; ld_addr_a = '0; ld_data_a = '0;
        ld_en_b = 1'b0; ld_addr_b = '0; ld_data_b = '0;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
        bus_a.req_wdata = '0; bus_a.rsp_ready = 1'b0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
        bus_b.req_wdata = '0; bus_b.rsp_ready = 1'b0;
        #1;
        reset_a = 1'b0; reset_b = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.req_ready", bus_a.req_ready, 0);
        chk("rst.rsp_valid", bus_a.rsp_valid, 0);
        chk("rst.rsp_rdata", bus_a.rsp_rdata, 16'h0000);
        chk("rst.busy_ld_err", {busy_a, ld_err_a}, 2'b00);
        chk("rst.b_req_ready", bus_b.req_ready, 0);
        @(negedge clk);
        reset_a = 1'b1; reset_b = 1'b1;
        @(negedge clk);
        chk("rel.req_ready", bus_a.req_ready, 1);

        // Program preload and fetches
        preload_a(12'h000, make_instr(OP_LOAD, 12'h005));
        preload_a(12'h001, make_instr(OP_ADD,  12'h123));
        preload_a(12'h002, make_instr(OP_JUMP, 12'h000));
        transact(1'b0, 12'h000, 16'h0, 16'h1005, 0, "rd0");
        transact(1'b0, 12'h001, 16'h0, 16'h2123, 0, "rd1");
        transact(1'b0, 12'h002, 16'h0, 16'h4000, 0, "rd2");

        // Write echo, then read-back with a stalled response
        transact(1'b1, 12'h0FF, 16'hBEEF, 16'hBEEF, 0, "wr0ff");
        transact(1'b0, 12'h0FF, 16'h0, 16'hBEEF, 5, "rd0ff_hold");

        // Preload collides with a pending request: preload wins, request next cycle
        ld_en_a = 1'b1; ld_addr_a = 12'h003; ld_data_a = 16'h0033;
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 12'h003;
        #1;
        chk("coll.req_ready", bus_a.req_ready, 0);
        @(negedge clk);
        ld_en_a = 1'b0;
        transact(1'b0, 12'h003, 16'h0, 16'h0033, 0, "coll_rd3");
        chk("ld_err.clear", ld_err_a, 0);

        // Preload during WAIT is dropped and flags ld_err
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 12'h001;
        bus_a.rsp_ready = 1'b1;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        chk("wait.busy", busy_a, 1);
        ld_en_a = 1'b1; ld_addr_a = 12'h001; ld_data_a = 16'hDEAD;
        @(negedge clk);
        ld_en_a = 1'b0;
        chk("ld_err.set", ld_err_a, 1);
        @(negedge clk);
        chk("wait_ld.rsp", {bus_a.rsp_valid, bus_a.rsp_rdata}, {1'b1, 16'h2123});
        @(negedge clk);
        transact(1'b0, 12'h001, 16'h0, 16'h2123, 0, "rd1_after_ld");
        chk("ld_err.sticky", ld_err_a, 1);

        // Reset during WAIT of a write abandons it
        preload_a(12'h010, 16'h0000);
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 12'h010;
        bus_a.req_wdata = 16'h1234; bus_a.rsp_ready = 1'b1;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        chk("rstmid.busy_before", busy_a, 1);
        reset_a = 1'b0;
        #1;
        chk("rstmid.outputs", {bus_a.rsp_valid, busy_a, bus_a.req_ready, ld_err_a}, 4'b0000);
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        transact(1'b0, 12'h010, 16'h0, 16'h0000, 0, "rd010_after_rst");

        // Zero-latency responder: back-to-back reads
        preload_b(12'hFFF, 16'hA5A5);
        preload_b(12'h000, 16'h5A5A);
        bus_b.req_valid = 1'b1; bus_b.req_we = 1'b0; bus_b.req_addr = 12'hFFF;
        bus_b.rsp_ready = 1'b1;
        #1;
        chk("b.req_ready", bus_b.req_ready, 1);
        @(negedge clk);
        chk("b.rsp_fff", {bus_b.rsp_valid, bus_b.rsp_rdata}, {1'b1, 16'hA5A5});
        bus_b.req_addr = 12'h000;
        @(negedge clk);
        chk("b.bubble", {bus_b.rsp_valid, busy_b, bus_b.req_ready}, 3'b001);
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        chk("b.rsp_000", {bus_b.rsp_valid, bus_b.rsp_rdata}, {1'b1, 16'h5A5A});
        @(negedge clk);
        chk("b.idle", {bus_b.rsp_valid, busy_b, bus_b.req_ready, ld_err_b}, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
